adder_64_sched: RTL and testbench

//  Round-robin scheduler sharing one multi-cycle 64-bit adder (din_en/dout_en handshake) among NREQ requesters.

---
 rtl/adder_sched_pkg.sv | 25 ++
 rtl/adder_64_sched_rr_arbiter.sv | 40 ++++
 rtl/adder_64_sched.sv | 175 +++++++++++++++++
 tb/tb_adder_64_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the round-robin adder scheduler.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_W       = 64;
  localparam int DEF_TIMEOUT = 15;

  // Smallest r with 2**r >= n; callers always pass n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((int'(32'd1) << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_64_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping modulo NREQ.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [ID_W:0] pos_s;

  // Scan from the pointer upward; one extra bit keeps the wrap exact for non-power-of-2 NREQ.
  always_comb begin
    gnt_o = {NREQ{1'b0}};
    idx_o = {ID_W{1'b0}};
    any_o = 1'b0;
    pos_s = {(ID_W+1){1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      pos_s = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (pos_s >= (ID_W+1)'(NREQ)) begin
        pos_s = pos_s - (ID_W+1)'(NREQ);
      end else begin
        pos_s = pos_s;
      end
      if (!any_o && req_i[pos_s[ID_W-1:0]]) begin
        any_o                   = 1'b1;
        gnt_o[pos_s[ID_W-1:0]]  = 1'b1;
        idx_o                   = pos_s[ID_W-1:0];
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/adder_64_sched.sv
// Round-robin scheduler feeding one shared multi-cycle adder; one op in flight at a time,
// results returned tagged with the requester index, with a watchdog on the adder's reply.
module adder_64_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W   = clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0] req_cin,
  output logic            add_din_en,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  output logic            add_cin,
  input  logic            add_dout_en,
  input  logic [W-1:0]    add_sum,
  input  logic            add_cout,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic            rsp_err
);

  localparam int CNT_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            din_en_q, din_en_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic            rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] gnt_s;
  logic [ID_W-1:0] idx_s;
  logic            any_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (idx_s),
    .any_o (any_s)
  );

  // Accept pulse is only visible in IDLE and never while reset is asserted.
  assign req_ready  = (state_q == IDLE && rst_n) ? gnt_s : {NREQ{1'b0}};
  assign add_din_en = din_en_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign add_cin    = cin_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;

  // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    din_en_d    = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          a_d      = req_a[int'(idx_s)*W +: W];
          b_d      = req_b[int'(idx_s)*W +: W];
          cin_d    = req_cin[idx_s];
          id_d     = idx_s;
          din_en_d = 1'b1;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving in the final watchdog cycle still counts as a result.
        if (add_dout_en) begin
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
          rsp_err_d   = 1'b0;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_sum_d   = {W{1'b0}};
          rsp_cout_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (rsp_id_q == ID_LAST) ? {ID_W{1'b0}} : rsp_id_q + ID_W'(1'b1);
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      ptr_q       <= {ID_W{1'b0}};
      id_q        <= {ID_W{1'b0}};
      din_en_q    <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      cin_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_sum_q   <= {W{1'b0}};
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      din_en_q    <= din_en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_adder_64_sched.sv
// Directed bench for adder_64_sched with a behavioural multi-cycle adder of configurable latency.
module tb_adder_64_sched;

  localparam int NREQ = 4;
  localparam int W = 64;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0] req_cin = '0;
  logic add_din_en, add_cin, add_dout_en, add_cout;
  logic [W-1:0] add_a, add_b, add_sum;
  logic rsp_valid, rsp_cout, rsp_err;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_sum;

  int checks = 0;
  int failures = 0;

  adder_64_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_din_en(add_din_en), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_dout_en(add_dout_en), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Adder model: result appears lat_cfg cycles after the din_en cycle.
  int lat_cfg = 4;
  bit never_done = 1'b0;
  logic mdl_busy_q, mdl_dout_q, mdl_cout_q;
  int mdl_cnt_q;
  logic [W-1:0] mdl_sum_q;
  logic [W:0] mdl_full_q;
  logic inj_dout = 1'b0;
  logic [W-1:0] inj_sum = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_busy_q <= 1'b0; mdl_dout_q <= 1'b0; mdl_cout_q <= 1'b0;
      mdl_cnt_q <= 0; mdl_sum_q <= '0; mdl_full_q <= '0;
    end else begin
      mdl_dout_q <= 1'b0;
      if (add_din_en) begin
        mdl_busy_q <= 1'b1;
        mdl_cnt_q <= 1;
        mdl_full_q <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
      end else if (mdl_busy_q) begin
        mdl_cnt_q <= mdl_cnt_q + 1;
        if (mdl_cnt_q == lat_cfg - 1 && !never_done) begin
          mdl_busy_q <= 1'b0;
          mdl_dout_q <= 1'b1;
          mdl_sum_q <= mdl_full_q[W-1:0];
          mdl_cout_q <= mdl_full_q[W];
        end
      end
    end
  end

  assign add_dout_en = mdl_dout_q | inj_dout;
  assign add_sum = inj_dout ? inj_sum : mdl_sum_q;
  assign add_cout = inj_dout ? 1'b1 : mdl_cout_q;

  // Protocol monitor: din_en count, overlapping ops, illegal accept pulses.
  int din_cnt = 0;
  bit inflight = 1'b0;
  bit din_overlap = 1'b0;
  bit bad_ready = 1'b0;
  always @(negedge clk) begin
    if (add_din_en) din_cnt <= din_cnt + 1;
    if ($countones(req_ready) > 1 || (req_ready != '0 && (add_din_en || rsp_valid))) bad_ready <= 1'b1;
    if (!rst_n) inflight <= 1'b0;
    else if (add_din_en) begin
      if (inflight) din_overlap <= 1'b1;
      inflight <= 1'b1;
    end else if (rsp_valid && rsp_ready) inflight <= 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] a_tab [NREQ] = '{64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
                                  64'h0123_4567_89AB_CDEF, 64'h0000_0000_FFFF_FFFF};
  logic [W-1:0] b_tab [NREQ] = '{64'h0000_0000_0000_0002, 64'h8000_0000_0000_0000,
                                  64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0001};
  logic cin_tab [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] sum_tab [NREQ] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0001,
                                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001};
  logic cout_tab [NREQ] = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_slot(input int s, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[s*W +: W] = a;
    req_b[s*W +: W] = b;
    req_cin[s] = c;
  endtask

  task automatic load_table();
    for (int s = 0; s < NREQ; s++) load_slot(s, a_tab[s], b_tab[s], cin_tab[s]);
  endtask

  // Raise req_valid[idx], wait for its accept, drop it; returns in the ISSUE cycle.
  task automatic grant_wait(input int idx);
    bit ok = 1'b0;
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      #1;
      if (req_ready[idx]) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid[idx] = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL grant_wait req=%0d got=no_grant exp=grant", idx); end
  endtask

  // Count edges from the current cycle until rsp_valid is seen.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < 60);
    checks++;
    if (!rsp_valid) begin failures++; $display("FAIL wait_rsp got=no_rsp_valid exp=rsp_valid"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_cout, rsp_id, add_din_en, add_cin, req_ready} !== 11'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {rsp_valid, rsp_err, rsp_cout, rsp_id, add_din_en, add_cin, req_ready});
    end
    checks++;
    if ({rsp_sum, add_a, add_b} !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", rsp_sum, add_a, add_b);
    end
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    int din0;
    load_slot(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    din0 = din_cnt;
    grant_wait(0);
    checks++;
    if (add_din_en !== 1'b1 || add_a !== 64'hFFFF_FFFF_FFFF_FFFF || add_b !== 64'd1 || add_cin !== 1'b0) begin
      failures++; $display("FAIL single_issue got=%b %h %h %b exp=1 ffffffffffffffff 1 0", add_din_en, add_a, add_b, add_cin);
    end
    tick();
    checks++;
    if (add_din_en !== 1'b0 || add_a !== 64'hFFFF_FFFF_FFFF_FFFF || add_b !== 64'd1) begin
      failures++; $display("FAIL single_hold got=%b %h %h exp=0 ffffffffffffffff 1", add_din_en, add_a, add_b);
    end
    wait_rsp(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", n); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b1 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL single_rsp got=%0d %h %b %b exp=0 0 1 0", rsp_id, rsp_sum, rsp_cout, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid); end
    checks++;
    if (din_cnt - din0 !== 1) begin failures++; $display("FAIL single_din_pulses got=%0d exp=1", din_cnt - din0); end
  endtask

  task automatic test_round_robin();
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    int gid [5];
    int gcyc [5];
    int ng = 0;
    int nr = 0;
    bit stop = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    load_table();
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 200 && nr < 5; cyc++) begin
      #1;
      if (req_ready != '0 && ng < 5) begin
        for (int b = 0; b < NREQ; b++) if (req_ready[b]) gid[ng] = b;
        gcyc[ng] = cyc;
        ng++;
        if (ng == 5) stop = 1'b1;
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== 2'(exp_ord[nr]) || rsp_sum !== sum_tab[exp_ord[nr]] ||
            rsp_cout !== cout_tab[exp_ord[nr]] || rsp_err !== 1'b0) begin
          failures++;
          $display("FAIL rr_rsp%0d got=%0d %h %b %b exp=%0d %h %b 0", nr, rsp_id, rsp_sum, rsp_cout, rsp_err,
                   exp_ord[nr], sum_tab[exp_ord[nr]], cout_tab[exp_ord[nr]]);
        end
        nr++;
      end
      @(posedge clk); #1;
      if (stop) req_valid = 4'h0;
    end
    checks++;
    if (ng !== 5 || nr !== 5) begin failures++; $display("FAIL rr_counts got=%0d/%0d exp=5/5", ng, nr); end
    for (int k = 0; k < ng; k++) begin
      checks++;
      if (gid[k] !== exp_ord[k]) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, gid[k], exp_ord[k]); end
    end
    checks++;
    if (ng >= 2 && gcyc[1] - gcyc[0] !== 7) begin
      failures++; $display("FAIL rr_grant_gap got=%0d exp=7", gcyc[1] - gcyc[0]);
    end
  endtask

  task automatic test_timeout();
    int n;
    load_table();
    never_done = 1'b1;
    grant_wait(2);
    wait_rsp(n);
    checks++;
    if (n !== 1 + TIMEOUT) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", n, 1 + TIMEOUT); end
    checks++;
    if (rsp_id !== 2'd2 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0 || rsp_err !== 1'b1) begin
      failures++; $display("FAIL timeout_rsp got=%0d %h %b %b exp=2 0 0 1", rsp_id, rsp_sum, rsp_cout, rsp_err);
    end
    tick();
    never_done = 1'b0;
    grant_wait(3);
    wait_rsp(n);
    checks++;
    if (n !== 5 || rsp_id !== 2'd3 || rsp_sum !== 64'h0000_0001_0000_0001 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL timeout_next got=%0d %0d %h %b exp=5 3 0000000100000001 0", n, rsp_id, rsp_sum, rsp_err);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    grant_wait(0);
    rsp_ready = 1'b0;
    wait_rsp(n);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 64'd3 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_hold%0d got=%b %0d %h %b exp=1 0 3 0000", k, rsp_valid, rsp_id, rsp_sum, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(n);
    checks++;
    if (rsp_id !== 2'd1 || rsp_sum !== 64'd1 || rsp_cout !== 1'b1) begin
      failures++; $display("FAIL bp_req1_rsp got=%0d %h %b exp=1 1 1", rsp_id, rsp_sum, rsp_cout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    grant_wait(0);
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_err, rsp_cout, rsp_id, add_din_en, add_cin, req_ready} !== 11'd0 ||
        {rsp_sum, add_a, add_b} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=%b %h %h exp=0", {rsp_valid, add_din_en, req_ready}, add_a, rsp_sum);
    end
    rst_n = 1'b1;
    tick();
    inj_sum = 64'hDEAD_BEEF_0000_0001;
    inj_dout = 1'b1;
    tick();
    inj_dout = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid || add_din_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midreset_stale got=activity exp=idle"); end
  endtask

  task automatic test_spurious_coincide();
    int n;
    bit seen = 1'b0;
    inj_sum = 64'h1234_5678_9ABC_DEF0;
    inj_dout = 1'b1;
    tick(); tick();
    inj_dout = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid || add_din_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL spurious_idle got=activity exp=idle"); end
    lat_cfg = TIMEOUT;
    grant_wait(3);
    wait_rsp(n);
    checks++;
    if (n !== 1 + TIMEOUT || rsp_err !== 1'b0 || rsp_id !== 2'd3 || rsp_sum !== 64'h0000_0001_0000_0001) begin
      failures++; $display("FAIL coincide_rsp got=%0d %b %0d %h exp=16 0 3 0000000100000001", n, rsp_err, rsp_id, rsp_sum);
    end
    tick();
    lat_cfg = TIMEOUT + 1;
    grant_wait(1);
    wait_rsp(n);
    checks++;
    if (n !== 1 + TIMEOUT || rsp_err !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 64'd0) begin
      failures++; $display("FAIL late_rsp got=%0d %b %0d %h exp=16 1 1 0", n, rsp_err, rsp_id, rsp_sum);
    end
    tick();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid || add_din_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin failures++; $display("FAIL late_stale got=activity exp=idle"); end
    lat_cfg = 4;
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_ready !== 1'b0) begin failures++; $display("FAIL inv_req_ready got=%b exp=0", bad_ready); end
    checks++;
    if (din_overlap !== 1'b0) begin failures++; $display("FAIL inv_din_overlap got=%b exp=0", din_overlap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_spurious_coincide();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
